// File: rtl/fifo_modport_pkg.sv
// Shared types and sizing for the fifo_modport FIFO.
// Optional build macro used by the FIFO: FIFO_FWFT_EN (first-word-fall-through).
package fifo_pkg;

    localparam int DATA_W    = 128;
    localparam int DEPTH     = 16;
    localparam int AFULL_TH  = 14;
    localparam int AEMPTY_TH = 2;
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int CNT_W     = PTR_W + 1;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    // Status flags, kept together so they register as one unit.
    typedef struct packed {
        logic full;
        logic alm_full;
        logic empty;
        logic alm_empty;
    } flags_t;

    // All four flags are a pure function of occupancy.
    function automatic flags_t flags_of(input cnt_t cnt);
        flags_t f;
        f.full      = (cnt == cnt_t'(DEPTH));
        f.alm_full  = (cnt >= cnt_t'(AFULL_TH));
        f.empty     = (cnt == cnt_t'(0));
        f.alm_empty = (cnt <= cnt_t'(AEMPTY_TH));
        return f;
    endfunction

endpackage

// File: rtl/fifo_modport_if.sv
// Producer/consumer-facing bus of the fifo_modport FIFO.
// master: the side driving requests; slave: the FIFO itself.
interface fifo_modport_if;
    import fifo_pkg::*;

    logic  i_wren;
    logic  i_rden;
    data_t i_wrdata;
    logic  o_full;
    logic  o_alm_full;
    logic  o_empty;
    logic  o_alm_empty;
    data_t o_rddata;

    modport master (
        output i_wren, i_rden, i_wrdata,
        input  o_full, o_alm_full, o_empty, o_alm_empty, o_rddata
    );

    modport slave (
        input  i_wren, i_rden, i_wrdata,
        output o_full, o_alm_full, o_empty, o_alm_empty, o_rddata
    );

endinterface

// File: rtl/fifo_modport_mem.sv
// fifo_mem: register-array storage with one write port and one
// asynchronous read port. Contents are never reset.
module fifo_mem
    import fifo_pkg::*;
(
    input  logic  clk,
    input  logic  we,
    input  ptr_t  waddr,
    input  data_t wdata,
    input  ptr_t  raddr,
    output data_t rdata
);

    data_t mem_r [DEPTH];

    // Store the write word at its address when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/fifo_modport.sv
// fifo_modport: synchronous single-clock FIFO with occupancy-derived flags.
// Build macro FIFO_FWFT_EN selects first-word-fall-through read data;
// without it the read data is registered with one cycle of latency.
module fifo_modport
    import fifo_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    fifo_modport_if.slave bus
);

    ptr_t   wptr_r;
    ptr_t   rptr_r;
    cnt_t   cnt_r;
    cnt_t   cnt_nxt_s;
    flags_t flags_r;
    logic   wr_ok_s;
    logic   rd_ok_s;
    logic   mem_we_s;
    data_t  mem_rdata_s;

    // Accept requests against the flags as they stood before the edge.
    always_comb begin
        wr_ok_s  = bus.i_wren && !flags_r.full;
        rd_ok_s  = bus.i_rden && !flags_r.empty;
        mem_we_s = wr_ok_s && !reset;
        case ({wr_ok_s, rd_ok_s})
            2'b10:   cnt_nxt_s = cnt_r + cnt_t'(1);
            2'b01:   cnt_nxt_s = cnt_r - cnt_t'(1);
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    // Pointers, occupancy and flags; flags follow the new count directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_r  <= ptr_t'(0);
            rptr_r  <= ptr_t'(0);
            cnt_r   <= cnt_t'(0);
            flags_r <= flags_of(cnt_t'(0));
        end else begin
            if (wr_ok_s) begin
                wptr_r <= wptr_r + ptr_t'(1);
            end
            if (rd_ok_s) begin
                rptr_r <= rptr_r + ptr_t'(1);
            end
            cnt_r   <= cnt_nxt_s;
            flags_r <= flags_of(cnt_nxt_s);
        end
    end

    fifo_mem u_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (wptr_r),
        .wdata (bus.i_wrdata),
        .raddr (rptr_r),
        .rdata (mem_rdata_s)
    );

`ifdef FIFO_FWFT_EN
    data_t rddata_s;

    // Head of the queue is visible directly; blank while empty or in reset.
    always_comb begin
        if (reset || flags_r.empty) begin
            rddata_s = '0;
        end else begin
            rddata_s = mem_rdata_s;
        end
    end

    assign bus.o_rddata = rddata_s;
`else
    data_t rddata_r;

    // Capture the head word on an accepted read, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            rddata_r <= '0;
        end else if (rd_ok_s) begin
            rddata_r <= mem_rdata_s;
        end
    end

    assign bus.o_rddata = rddata_r;
`endif

    assign bus.o_full      = flags_r.full;
    assign bus.o_alm_full  = flags_r.alm_full;
    assign bus.o_empty     = flags_r.empty;
    assign bus.o_alm_empty = flags_r.alm_empty;

endmodule

// File: tb/tb_fifo_modport.sv
// Directed self-checking bench for fifo_modport (default, registered-read build).
module tb_fifo_modport;
    import fifo_pkg::*;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    fifo_modport_if bus ();

    fifo_modport dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flags packed as {full, alm_full, empty, alm_empty}.
    function automatic logic [3:0] obs_flags();
        return {bus.o_full, bus.o_alm_full, bus.o_empty, bus.o_alm_empty};
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.i_wren = 1'b1;
        bus.i_rden = 1'b0;
        bus.i_wrdata = 128'hBEEF;
        cycle();
        cycle();
        n_cmp++;
        if (obs_flags() !== 4'b0011) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected %b", obs_flags(), 4'b0011);
        end
        n_cmp++;
        if (bus.o_rddata !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_rddata: got %0h expected 0", bus.o_rddata);
        end
        n_cmp++;
        if (dut.cnt_r !== 5'd0 || dut.wptr_r !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_count: got cnt %0d wptr %0d expected 0 0", dut.cnt_r, dut.wptr_r);
        end
        bus.i_wren = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_fill_drain();
        logic [3:0] ef;
        for (int i = 1; i <= 16; i++) begin
            bus.i_wren = 1'b1;
            bus.i_wrdata = data_t'(i);
            cycle();
            ef = {i == 16, i >= 14, 1'b0, i <= 2};
            n_cmp++;
            if (obs_flags() !== ef) begin
                n_fail++;
                $display("FAIL fill_flags[%0d]: got %b expected %b", i, obs_flags(), ef);
            end
        end
        bus.i_wrdata = 128'hDEAD;
        cycle();
        bus.i_wren = 1'b0;
        n_cmp++;
        if (dut.cnt_r !== 5'd16 || obs_flags() !== 4'b1100) begin
            n_fail++;
            $display("FAIL overflow_drop: got cnt %0d flags %b expected 16 1100", dut.cnt_r, obs_flags());
        end
        for (int i = 1; i <= 16; i++) begin
            bus.i_rden = 1'b1;
            cycle();
            ef = {1'b0, (16 - i) >= 14, (16 - i) == 0, (16 - i) <= 2};
            n_cmp++;
            if (bus.o_rddata !== data_t'(i)) begin
                n_fail++;
                $display("FAIL drain_data[%0d]: got %0h expected %0h", i, bus.o_rddata, i);
            end
            n_cmp++;
            if (obs_flags() !== ef) begin
                n_fail++;
                $display("FAIL drain_flags[%0d]: got %b expected %b", i, obs_flags(), ef);
            end
        end
        bus.i_rden = 1'b0;
    endtask

    task automatic test_underflow();
        for (int i = 0; i < 3; i++) begin
            bus.i_rden = 1'b1;
            cycle();
            n_cmp++;
            if (bus.o_rddata !== 128'h10 || obs_flags() !== 4'b0011 || dut.cnt_r !== 5'd0) begin
                n_fail++;
                $display("FAIL underflow[%0d]: got data %0h flags %b cnt %0d expected 10 0011 0",
                         i, bus.o_rddata, obs_flags(), dut.cnt_r);
            end
        end
        bus.i_rden = 1'b0;
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 5; i++) begin
            bus.i_wren = 1'b1;
            bus.i_wrdata = data_t'(32'h101 + i);
            cycle();
        end
        n_cmp++;
        if (dut.cnt_r !== 5'd5) begin
            n_fail++;
            $display("FAIL sim_preload: got cnt %0d expected 5", dut.cnt_r);
        end
        // 14 cycles move the write pointer from 5 past 15 round to 3.
        for (int k = 0; k < 14; k++) begin
            bus.i_wren = 1'b1;
            bus.i_rden = 1'b1;
            bus.i_wrdata = data_t'(32'h106 + k);
            cycle();
            n_cmp++;
            if (bus.o_rddata !== data_t'(32'h101 + k) || dut.cnt_r !== 5'd5 || obs_flags() !== 4'b0000) begin
                n_fail++;
                $display("FAIL sim_rw[%0d]: got data %0h cnt %0d flags %b expected %0h 5 0000",
                         k, bus.o_rddata, dut.cnt_r, obs_flags(), 32'h101 + k);
            end
        end
        bus.i_wren = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.i_rden = 1'b1;
            cycle();
            n_cmp++;
            if (bus.o_rddata !== data_t'(32'h10F + k)) begin
                n_fail++;
                $display("FAIL sim_drain[%0d]: got %0h expected %0h", k, bus.o_rddata, 32'h10F + k);
            end
        end
        bus.i_rden = 1'b0;
        n_cmp++;
        if (obs_flags() !== 4'b0011) begin
            n_fail++;
            $display("FAIL sim_empty: got %b expected 0011", obs_flags());
        end
    endtask

    task automatic test_full_boundary();
        for (int i = 0; i < 16; i++) begin
            bus.i_wren = 1'b1;
            bus.i_wrdata = data_t'(32'h201 + i);
            cycle();
        end
        n_cmp++;
        if (obs_flags() !== 4'b1100) begin
            n_fail++;
            $display("FAIL fb_full: got %b expected 1100", obs_flags());
        end
        bus.i_rden = 1'b1;
        bus.i_wrdata = 128'hBAD;
        cycle();
        bus.i_wren = 1'b0;
        n_cmp++;
        if (bus.o_rddata !== 128'h201 || obs_flags() !== 4'b0100 || dut.cnt_r !== 5'd15) begin
            n_fail++;
            $display("FAIL fb_rw: got data %0h flags %b cnt %0d expected 201 0100 15",
                     bus.o_rddata, obs_flags(), dut.cnt_r);
        end
        for (int k = 0; k < 15; k++) begin
            cycle();
            n_cmp++;
            if (bus.o_rddata !== data_t'(32'h202 + k)) begin
                n_fail++;
                $display("FAIL fb_drain[%0d]: got %0h expected %0h", k, bus.o_rddata, 32'h202 + k);
            end
        end
        bus.i_rden = 1'b0;
        n_cmp++;
        if (obs_flags() !== 4'b0011) begin
            n_fail++;
            $display("FAIL fb_empty: got %b expected 0011", obs_flags());
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 9; i++) begin
            bus.i_wren = 1'b1;
            bus.i_wrdata = data_t'(32'h301 + i);
            cycle();
        end
        n_cmp++;
        if (dut.cnt_r !== 5'd9) begin
            n_fail++;
            $display("FAIL mr_preload: got cnt %0d expected 9", dut.cnt_r);
        end
        reset = 1'b1;
        bus.i_wrdata = 128'h999;
        cycle();
        reset = 1'b0;
        bus.i_wren = 1'b0;
        n_cmp++;
        if (obs_flags() !== 4'b0011 || bus.o_rddata !== 128'h0 || dut.cnt_r !== 5'd0) begin
            n_fail++;
            $display("FAIL mr_reset: got flags %b data %0h cnt %0d expected 0011 0 0",
                     obs_flags(), bus.o_rddata, dut.cnt_r);
        end
        // Read and write together while empty: only the write lands.
        bus.i_wren = 1'b1;
        bus.i_rden = 1'b1;
        bus.i_wrdata = 128'hA5;
        cycle();
        bus.i_wren = 1'b0;
        n_cmp++;
        if (bus.o_rddata !== 128'h0 || dut.cnt_r !== 5'd1 || obs_flags() !== 4'b0001) begin
            n_fail++;
            $display("FAIL mr_empty_rw: got data %0h cnt %0d flags %b expected 0 1 0001",
                     bus.o_rddata, dut.cnt_r, obs_flags());
        end
        cycle();
        bus.i_rden = 1'b0;
        n_cmp++;
        if (bus.o_rddata !== 128'hA5 || obs_flags() !== 4'b0011) begin
            n_fail++;
            $display("FAIL mr_readback: got data %0h flags %b expected a5 0011", bus.o_rddata, obs_flags());
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        reset = 1'b1;
        bus.i_wren = 1'b0;
        bus.i_rden = 1'b0;
        bus.i_wrdata = '0;
        test_reset();
        test_fill_drain();
        test_underflow();
        test_simultaneous();
        test_full_boundary();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
